credit_ledger: RTL

Coin-credit accumulator and change dispenser that sits directly upstream of the beverage-vending controller. It counts inserted 100 and 500 coins in units of 100, and drives the coin-reject flag and the four "credit sufficient" flags the controller samples. On a completed sale or a cancel it ejects change as a timed sequence of 500/100 coin pulses.

---
 rtl/vending_pkg.sv | 27 ++
 rtl/credit_ledger_if.sv | 37 +++
 rtl/coin_ejector.sv | 78 +++++++
 rtl/credit_ledger.sv | 118 +++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared vending definitions: coin values, default drink prices and the FSM state
// encodings used by the credit ledger and its coin ejector.
package vending_pkg;

  localparam int COIN_CIEN = 1;
  localparam int COIN_QUIN = 5;

  localparam int DEF_PRICE_1 = 3;
  localparam int DEF_PRICE_2 = 4;
  localparam int DEF_PRICE_3 = 5;
  localparam int DEF_PRICE_4 = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } pay_state_t;

  typedef enum logic [1:0] {
    EJ_IDLE  = 2'd0,
    EJ_PULSE = 2'd1,
    EJ_GAP   = 2'd2
  } ej_phase_t;

endpackage

// File: rtl/credit_ledger_if.sv
// Signal bundle between the vending controller (master) and the credit ledger (slave),
// including the ledger's FSM states for observation.
interface credit_ledger_if #(
  parameter int CREDIT_W = 8
);
  import vending_pkg::*;

  logic                en_cien;
  logic                en_quin;
  logic                producto;
  logic                rst_cuenta;
  logic [7:0]          valor_producto;
  logic                m0;
  logic                m1;
  logic                m2;
  logic                m3;
  logic                m4;
  logic [CREDIT_W-1:0] credit;
  logic                out_quin;
  logic                out_cien;
  logic                busy;
  logic                pay_done;
  pay_state_t          pay_state;
  ej_phase_t           ej_phase;

  modport master (
    output en_cien, en_quin, producto, rst_cuenta, valor_producto,
    input  m0, m1, m2, m3, m4, credit, out_quin, out_cien, busy, pay_done,
    input  pay_state, ej_phase
  );

  modport slave (
    input  en_cien, en_quin, producto, rst_cuenta, valor_producto,
    output m0, m1, m2, m3, m4, credit, out_quin, out_cien, busy, pay_done,
    output pay_state, ej_phase
  );
endinterface

// File: rtl/coin_ejector.sv
// Generates one eject pulse of PULSE_LEN cycles followed by a GAP_LEN low gap.
// Handshake: start (with coin_sel) is honoured only in EJ_IDLE; coin_done pulses in the last gap cycle.
module coin_ejector
  import vending_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      coin_sel,
  output logic      out_quin,
  output logic      out_cien,
  output logic      pulse_last,
  output logic      coin_done,
  output ej_phase_t phase_dbg
);
  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ej_phase_t        phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sel, sel_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= EJ_IDLE;
      cnt   <= '0;
      sel   <= 1'b0;
    end else begin
      phase <= phase_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
    end
  end

  always_comb begin
    phase_n    = phase;
    cnt_n      = cnt;
    sel_n      = sel;
    pulse_last = 1'b0;
    coin_done  = 1'b0;
    unique case (phase)
      EJ_IDLE: begin
        if (start) begin
          phase_n = EJ_PULSE;
          cnt_n   = '0;
          sel_n   = coin_sel;
        end
      end
      EJ_PULSE: begin
        if (cnt == CNT_W'(PULSE_LEN - 1)) begin
          pulse_last = 1'b1;
          phase_n    = EJ_GAP;
          cnt_n      = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      EJ_GAP: begin
        if (cnt == CNT_W'(GAP_LEN - 1)) begin
          coin_done = 1'b1;
          phase_n   = EJ_IDLE;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: phase_n = EJ_IDLE;
    endcase
  end

  assign out_quin  = (phase == EJ_PULSE) &&  sel;
  assign out_cien  = (phase == EJ_PULSE) && !sel;
  assign phase_dbg = phase;

endmodule

// File: rtl/credit_ledger.sv
// Coin credit accumulator with price flags and a change payout sequencer that
// drives coin_ejector one coin at a time, largest coin first.
module credit_ledger
  import vending_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 20,
  parameter int PRICE_1    = DEF_PRICE_1,
  parameter int PRICE_2    = DEF_PRICE_2,
  parameter int PRICE_3    = DEF_PRICE_3,
  parameter int PRICE_4    = DEF_PRICE_4,
  parameter int PULSE_LEN  = 4,
  parameter int GAP_LEN    = 2
) (
  input logic            clk,
  input logic            rst,
  credit_ledger_if.slave bus
);
  pay_state_t          state, state_n;
  logic [CREDIT_W-1:0] credit;
  logic                prod_q;
  logic                prod_rise, trig, busy, m0;
  logic                start, coin_sel, pulse_last, coin_done;
  logic [CREDIT_W:0]   cred_p1, cred_p5;
  logic [CREDIT_W+7:0] cred_ext, price_ext;

  assign busy      = (state != ST_IDLE);
  assign prod_rise = bus.producto & ~prod_q;
  assign trig      = bus.rst_cuenta | prod_rise;

  assign cred_p1 = {1'b0, credit} + (CREDIT_W+1)'(COIN_CIEN);
  assign cred_p5 = {1'b0, credit} + (CREDIT_W+1)'(COIN_QUIN);
  assign m0 = busy
            | (bus.en_cien & (cred_p1 > (CREDIT_W+1)'(MAX_CREDIT)))
            | (bus.en_quin & (cred_p5 > (CREDIT_W+1)'(MAX_CREDIT)));

  assign cred_ext  = (CREDIT_W+8)'(credit);
  assign price_ext = (CREDIT_W+8)'(bus.valor_producto);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      credit <= '0;
      prod_q <= 1'b0;
    end else begin
      state  <= state_n;
      prod_q <= bus.producto;
      if (state == ST_IDLE) begin
        // A cancel in the same cycle as a sale refunds everything, so it is checked first.
        if (bus.rst_cuenta) begin
          credit <= credit;
        end else if (prod_rise) begin
          credit <= (cred_ext > price_ext) ? CREDIT_W'(cred_ext - price_ext) : '0;
        end else if (bus.en_quin) begin
          if (!m0) credit <= credit + CREDIT_W'(COIN_QUIN);
        end else if (bus.en_cien && !m0) begin
          credit <= credit + CREDIT_W'(COIN_CIEN);
        end
      end else if (state == ST_PULSE && pulse_last) begin
        credit <= credit - (bus.out_quin ? CREDIT_W'(COIN_QUIN) : CREDIT_W'(COIN_CIEN));
      end
    end
  end

  always_comb begin
    state_n      = state;
    start        = 1'b0;
    coin_sel     = 1'b0;
    bus.pay_done = 1'b0;
    unique case (state)
      ST_IDLE:  if (trig) state_n = ST_CHECK;
      ST_CHECK: begin
        if (credit >= CREDIT_W'(COIN_QUIN)) begin
          start    = 1'b1;
          coin_sel = 1'b1;
          state_n  = ST_PULSE;
        end else if (credit >= CREDIT_W'(COIN_CIEN)) begin
          start   = 1'b1;
          state_n = ST_PULSE;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_PULSE: if (pulse_last) state_n = ST_GAP;
      ST_GAP:   if (coin_done)  state_n = ST_CHECK;
      ST_DONE: begin
        bus.pay_done = 1'b1;
        state_n      = ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  coin_ejector #(
    .PULSE_LEN (PULSE_LEN),
    .GAP_LEN   (GAP_LEN)
  ) u_ejector (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .coin_sel   (coin_sel),
    .out_quin   (bus.out_quin),
    .out_cien   (bus.out_cien),
    .pulse_last (pulse_last),
    .coin_done  (coin_done),
    .phase_dbg  (bus.ej_phase)
  );

  assign bus.m0        = m0;
  assign bus.m1        = !busy && (credit >= CREDIT_W'(PRICE_1));
  assign bus.m2        = !busy && (credit >= CREDIT_W'(PRICE_2));
  assign bus.m3        = !busy && (credit >= CREDIT_W'(PRICE_3));
  assign bus.m4        = !busy && (credit >= CREDIT_W'(PRICE_4));
  assign bus.credit    = credit;
  assign bus.busy      = busy;
  assign bus.pay_state = state;

endmodule
